// File: rtl/game_score_keeper.sv
// Round score, session high score and final-score handshake for the screen timer.
// Optional consecutive-catch streak multiplier is enabled by defining GAME_SCORE_STREAK_EN.
module game_score_keeper #(
    parameter int SCORE_W          = 16,
    parameter int POINTS_PER_CATCH = 10,
    parameter int SNITCH_BONUS     = 150,
    parameter int MISS_PENALTY     = 5
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [4:0]         curr_screen,
    input  logic [5:0]         total_screens,
    input  logic               snitch_powerup,
    input  logic               end_of_game,
    input  logic               play_again,
    input  logic               catch_pulse,
    input  logic               miss_pulse,
    input  logic               scoreboard_ack,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [SCORE_W-1:0] final_score,
    output logic               scoreboard_valid,
    output logic               screen_change,
    output logic [2:0]         streak,
    output logic [1:0]         state
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PLAY         = 2'd1;
    localparam logic [1:0] REPORT       = 2'd2;
    localparam logic [1:0] WAIT_RESTART = 2'd3;

    localparam int DW = SCORE_W + 2;
    localparam logic signed [DW-1:0] PTS       = DW'(POINTS_PER_CATCH);
    localparam logic signed [DW-1:0] BONUS     = DW'(SNITCH_BONUS);
    localparam logic signed [DW-1:0] PENALTY   = DW'(MISS_PENALTY);
    localparam logic signed [DW-1:0] SCORE_MAX = {2'b00, {SCORE_W{1'b1}}};

    function automatic logic [SCORE_W-1:0] sat_score(input logic signed [DW-1:0] v);
        if (v < 0)
            return '0;
        else if (v > SCORE_MAX)
            return '1;
        else
            return v[SCORE_W-1:0];
    endfunction

    logic [1:0]         state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] high_q, high_d;
    logic [SCORE_W-1:0] final_q, final_d;
    logic               valid_q, valid_d;
    logic [4:0]         prev_screen_q;
    logic               screen_change_q;
    logic               snitch_taken_q, snitch_taken_d;
    logic [2:0]         streak_q, streak_d;
    logic               eog_q, eog_prev_q;

    logic                 trace;
    logic                 catch_ok;
    logic                 miss_ok;
    logic                 snitch_held;
    logic                 bonus;
    logic                 eog_rise;
    logic signed [DW-1:0] catch_pts;
    logic signed [DW-1:0] delta;
    logic signed [DW-1:0] score_sum;
    logic [SCORE_W-1:0]   score_upd;
    logic [2:0]           streak_upd;

    assign trace = ~curr_screen[0] && (curr_screen >= 5'd2)
                   && ({1'b0, curr_screen} < total_screens);
    assign catch_ok = catch_pulse && (state_q == PLAY) && trace;
    assign miss_ok  = miss_pulse && (state_q == PLAY) && trace;

    // A screen change in this cycle means the catch belongs to the new screen.
    assign snitch_held = snitch_taken_q && !screen_change_q;
    assign bonus       = catch_ok && snitch_powerup && !snitch_held;
    assign eog_rise    = eog_q && !eog_prev_q;

`ifdef GAME_SCORE_STREAK_EN
    logic [2:0] streak_eff;
    assign streak_eff = screen_change_q ? 3'd0 : streak_q;
    assign catch_pts  = (streak_eff >= 3'd4) ? (PTS + PTS) : PTS;

    always_comb begin
        streak_upd = streak_eff;
        if (miss_ok)
            streak_upd = 3'd0;
        else if (catch_ok)
            streak_upd = (streak_eff == 3'd7) ? 3'd7 : streak_eff + 3'd1;
    end
`else
    assign catch_pts  = PTS;
    assign streak_upd = 3'd0;
`endif

    assign delta = (catch_ok ? catch_pts : '0) + (bonus ? BONUS : '0)
                 - (miss_ok ? PENALTY : '0);
    assign score_sum = $signed({2'b00, score_q}) + delta;
    assign score_upd = sat_score(score_sum);

    always_comb begin
        state_d        = state_q;
        score_d        = score_upd;
        high_d         = high_q;
        final_d        = final_q;
        valid_d        = valid_q;
        snitch_taken_d = bonus || snitch_held;
        streak_d       = streak_upd;
        case (state_q)
            IDLE: begin
                if (trace)
                    state_d = PLAY;
            end
            PLAY: begin
                if (eog_rise) begin
                    state_d = REPORT;
                    final_d = score_upd;
                    valid_d = 1'b1;
                    if (score_upd > high_q)
                        high_d = score_upd;
                end
            end
            REPORT: begin
                if (scoreboard_ack) begin
                    valid_d = 1'b0;
                    state_d = WAIT_RESTART;
                end
            end
            default: begin
                // A level check covers both a fresh rise and a level already held on entry.
                if (play_again) begin
                    state_d        = IDLE;
                    score_d        = '0;
                    streak_d       = 3'd0;
                    snitch_taken_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q         <= IDLE;
            score_q         <= '0;
            high_q          <= '0;
            final_q         <= '0;
            valid_q         <= 1'b0;
            prev_screen_q   <= curr_screen;
            screen_change_q <= 1'b0;
            snitch_taken_q  <= 1'b0;
            streak_q        <= 3'd0;
            eog_q           <= 1'b0;
            eog_prev_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            score_q         <= score_d;
            high_q          <= high_d;
            final_q         <= final_d;
            valid_q         <= valid_d;
            prev_screen_q   <= curr_screen;
            screen_change_q <= (curr_screen != prev_screen_q);
            snitch_taken_q  <= snitch_taken_d;
            streak_q        <= streak_d;
            eog_q           <= end_of_game;
            eog_prev_q      <= eog_q;
        end
    end

    assign score            = score_q;
    assign high_score       = high_q;
    assign final_score      = final_q;
    assign scoreboard_valid = valid_q;
    assign screen_change    = screen_change_q;
    assign streak           = streak_q;
    assign state            = state_q;

endmodule

// File: tb/tb_game_score_keeper.sv
// Scoreboard bench for game_score_keeper: stimulus queues expectations, a negedge monitor checks them.
module tb_game_score_keeper;

    localparam int SW = 16;

    logic          clock;
    logic          resetn;
    logic [4:0]    curr_screen;
    logic [5:0]    total_screens;
    logic          snitch_powerup;
    logic          end_of_game;
    logic          play_again;
    logic          catch_pulse;
    logic          miss_pulse;
    logic          scoreboard_ack;
    logic [SW-1:0] score;
    logic [SW-1:0] high_score;
    logic [SW-1:0] final_score;
    logic          scoreboard_valid;
    logic          screen_change;
    logic [2:0]    streak;
    logic [1:0]    state;

    game_score_keeper dut (
        .clock           (clock),
        .resetn          (resetn),
        .curr_screen     (curr_screen),
        .total_screens   (total_screens),
        .snitch_powerup  (snitch_powerup),
        .end_of_game     (end_of_game),
        .play_again      (play_again),
        .catch_pulse     (catch_pulse),
        .miss_pulse      (miss_pulse),
        .scoreboard_ack  (scoreboard_ack),
        .score           (score),
        .high_score      (high_score),
        .final_score     (final_score),
        .scoreboard_valid(scoreboard_valid),
        .screen_change   (screen_change),
        .streak          (streak),
        .state           (state)
    );

    localparam int F_SCORE = 0, F_HIGH = 1, F_FINAL = 2, F_VALID = 3;
    localparam int F_SC = 4, F_STREAK = 5, F_STATE = 6, F_PENDING = 7;

    typedef struct {
        int          field;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rpt_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [31:0] get_field(input int f);
        case (f)
            F_SCORE:  return 32'(score);
            F_HIGH:   return 32'(high_score);
            F_FINAL:  return 32'(final_score);
            F_VALID:  return 32'(scoreboard_valid);
            F_SC:     return 32'(screen_change);
            F_STREAK: return 32'(streak);
            F_STATE:  return 32'(state);
            default:  return 32'(rpt_q.size());
        endcase
    endfunction

    // Monitor: drains queued expectations and checks every final-score report.
    logic valid_seen = 1'b0;
    always @(negedge clock) begin
        exp_t        e;
        logic [31:0] act;
        logic [31:0] r;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = get_field(e.field);
            vectors++;
            if (act !== e.exp) begin
                miscompares++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
        if (scoreboard_valid === 1'b1 && !valid_seen) begin
            vectors++;
            if (rpt_q.size() == 0) begin
                miscompares++;
                $display("FAIL report: got unexpected valid with final_score %0d expected no report", final_score);
            end else begin
                r = rpt_q.pop_front();
                if (32'(final_score) !== r) begin
                    miscompares++;
                    $display("FAIL report: got final_score %0d expected %0d", final_score, r);
                end
            end
        end
        valid_seen = (scoreboard_valid === 1'b1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_v(input int f, input logic [31:0] v, input string n);
        exp_q.push_back('{f, v, n});
    endtask

    task automatic pulse(input logic c, input logic m, input logic s);
        catch_pulse    = c;
        miss_pulse     = m;
        snitch_powerup = s;
        step();
        catch_pulse    = 1'b0;
        miss_pulse     = 1'b0;
        snitch_powerup = 1'b0;
    endtask

    initial begin
        resetn = 0; curr_screen = 5'd3; total_screens = 6'd8;
        snitch_powerup = 0; end_of_game = 0; play_again = 0;
        catch_pulse = 0; miss_pulse = 0; scoreboard_ack = 0;
        step(); step();
        expect_v(F_SCORE, 0, "rst_score");   expect_v(F_HIGH, 0, "rst_high");
        expect_v(F_FINAL, 0, "rst_final");   expect_v(F_VALID, 0, "rst_valid");
        expect_v(F_SC, 0, "rst_sc");         expect_v(F_STREAK, 0, "rst_streak");
        expect_v(F_STATE, 0, "rst_state");
        resetn = 1; step();
        expect_v(F_SC, 0, "no_sc_after_rst"); expect_v(F_STATE, 0, "idle_odd_screen");
        curr_screen = 5'd4; step();
        expect_v(F_SC, 1, "sc_pulse");       expect_v(F_STATE, 1, "enter_play");
        step();
        expect_v(F_SC, 0, "sc_one_cycle");

        // Round 1: 3 catches, miss, two snitch catches.
        pulse(1, 0, 0); expect_v(F_SCORE, 10, "catch1");
        pulse(1, 0, 0); expect_v(F_SCORE, 20, "catch2");
        pulse(1, 0, 0); expect_v(F_SCORE, 30, "catch3");
        pulse(0, 1, 0); expect_v(F_SCORE, 25, "miss1");
        pulse(1, 0, 1); expect_v(F_SCORE, 185, "snitch_first");
        pulse(1, 0, 1); expect_v(F_SCORE, 195, "snitch_once");
`ifdef GAME_SCORE_STREAK_EN
        expect_v(F_STREAK, 2, "r1_streak");
`else
        expect_v(F_STREAK, 0, "streak_tied");
`endif
        rpt_q.push_back(195);
        end_of_game = 1; step();
        expect_v(F_STATE, 1, "eog_reg_cycle"); expect_v(F_VALID, 0, "eog_no_valid_yet");
        step();
        expect_v(F_STATE, 2, "report");      expect_v(F_VALID, 1, "valid_rise");
        expect_v(F_FINAL, 195, "final_r1"); expect_v(F_HIGH, 195, "high_r1");
        repeat (8) step();
        expect_v(F_VALID, 1, "valid_held"); expect_v(F_FINAL, 195, "final_held");
        scoreboard_ack = 1; step();
        expect_v(F_VALID, 0, "valid_after_ack"); expect_v(F_STATE, 3, "wait_restart");
        scoreboard_ack = 0; end_of_game = 0; step();
        expect_v(F_STATE, 3, "wait_hold");   expect_v(F_SCORE, 195, "score_held");
        play_again = 1; step();
        expect_v(F_STATE, 0, "restart_idle"); expect_v(F_SCORE, 0, "restart_clear");

        // Round 2: ignored catches, then 100 points.
        catch_pulse = 1; step();
        expect_v(F_STATE, 1, "r2_play");     expect_v(F_SCORE, 0, "idle_catch_ignored");
        curr_screen = 5'd5; step();
        expect_v(F_SCORE, 0, "odd_screen_ignored"); expect_v(F_SC, 1, "sc_4_5");
        curr_screen = 5'd8; step();
        expect_v(F_SCORE, 0, "beyond_total_ignored");
        catch_pulse = 0; curr_screen = 5'd6; step();
        expect_v(F_SC, 1, "sc_8_6");
        repeat (4) begin
            pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 1, 0);
        end
        expect_v(F_SCORE, 100, "r2_score");
        rpt_q.push_back(100);
        end_of_game = 1; scoreboard_ack = 1; step();
        step();
        expect_v(F_VALID, 1, "r2_valid");    expect_v(F_FINAL, 100, "final_r2");
        expect_v(F_HIGH, 195, "high_kept");
        step();
        expect_v(F_VALID, 0, "ack_preheld"); expect_v(F_STATE, 3, "r2_wait");
        step();
        expect_v(F_STATE, 0, "play_again_held"); expect_v(F_SCORE, 0, "r2_clear");
        scoreboard_ack = 0; end_of_game = 0; step();
        expect_v(F_STATE, 1, "r3_play");

        // Round 3: floor, simultaneous catch/miss, saturation.
        pulse(0, 1, 0); expect_v(F_SCORE, 0, "floor");
        pulse(1, 1, 0); expect_v(F_SCORE, 5, "catch_and_miss");
        expect_v(F_STREAK, 0, "streak_after_both");
        repeat (2620) begin
            pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 1, 0);
        end
        expect_v(F_SCORE, 65505, "ramp");
        pulse(1, 0, 0); pulse(1, 0, 0); pulse(0, 1, 0); pulse(1, 0, 0);
        expect_v(F_SCORE, 65530, "near_max");
        pulse(1, 0, 0); expect_v(F_SCORE, 65535, "saturate");
        rpt_q.push_back(65535);
        end_of_game = 1; step(); step();
        expect_v(F_VALID, 1, "r3_valid");    expect_v(F_HIGH, 65535, "high_r3");
        end_of_game = 0; resetn = 0; step();
        expect_v(F_VALID, 0, "rst_in_report_valid"); expect_v(F_HIGH, 0, "rst_in_report_high");
        expect_v(F_FINAL, 0, "rst_in_report_final"); expect_v(F_STATE, 0, "rst_in_report_state");
        expect_v(F_SCORE, 0, "rst_in_report_score");
        resetn = 1; step();
        expect_v(F_STATE, 1, "r4_play");

        // Round 4: snitch clears on screen change; catch on eog transition counts.
        pulse(1, 0, 1); expect_v(F_SCORE, 160, "r4_snitch");
        pulse(1, 0, 1); expect_v(F_SCORE, 170, "r4_snitch_taken");
        curr_screen = 5'd4; step();
        expect_v(F_SC, 1, "sc_6_4");
        pulse(1, 0, 1); expect_v(F_SCORE, 330, "snitch_on_sc_cycle");
        pulse(1, 0, 1); expect_v(F_SCORE, 340, "snitch_new_taken");
        rpt_q.push_back(350);
        end_of_game = 1; step();
        catch_pulse = 1; step();
        expect_v(F_STATE, 2, "r4_report");   expect_v(F_FINAL, 350, "final_incl_catch");
        expect_v(F_HIGH, 350, "high_r4");    expect_v(F_SCORE, 350, "score_r4");
        catch_pulse = 0; end_of_game = 0; scoreboard_ack = 1; step();
        expect_v(F_VALID, 0, "r4_ack");
        scoreboard_ack = 0; step();
        expect_v(F_STATE, 0, "r4_idle");

`ifdef GAME_SCORE_STREAK_EN
        resetn = 0; curr_screen = 5'd6; step();
        resetn = 1; step();
        curr_screen = 5'd2; step();
        expect_v(F_STATE, 1, "streak_play");
        pulse(1, 0, 0); expect_v(F_SCORE, 10, "st1");
        pulse(1, 0, 0); expect_v(F_SCORE, 20, "st2");
        pulse(1, 0, 0); expect_v(F_SCORE, 30, "st3");
        pulse(1, 0, 0); expect_v(F_SCORE, 40, "st4");
        pulse(1, 0, 0); expect_v(F_SCORE, 60, "st5_doubled");
        pulse(1, 0, 0); expect_v(F_SCORE, 80, "st6_doubled");
        expect_v(F_STREAK, 6, "streak6");
        pulse(0, 1, 0); expect_v(F_SCORE, 75, "streak_miss");
        expect_v(F_STREAK, 0, "streak_cleared");
`endif

        expect_v(F_PENDING, 0, "reports_pending");
        step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
